// File: rtl/sobel_frame_controller.sv
// sobel_frame_controller: frame sequencer and 2-entry result FIFO wrapped around the Sobel datapath
//   clk_i, rst_ni          clock (rising edge) and asynchronous active-low reset
//   start_i, thresh_in_i   frame start (honoured in IDLE) and threshold latched with it
//   pix_valid_i/pix_data_i/pix_ready_o   upstream pixel handshake
//   dp_reset_o, dp_enable_o, dp_data_in_o, dp_t_o   datapath control
//   dp_is_ready_i, dp_is_end_i, dp_dop_i, dp_gradient_i, dp_row_i, dp_col_i   datapath status/results
//   res_valid_o/res_ready_i, res_row_o, res_col_o, res_grad_o, res_edge_o   result FIFO head
//   busy_o, done_o, edge_count_o   frame status and saturating per-frame edge count
module sobel_frame_controller #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [DW-1:0] thresh_in_i,
    input  logic          pix_valid_i,
    input  logic [DW-1:0] pix_data_i,
    output logic          pix_ready_o,
    output logic          dp_reset_o,
    output logic          dp_enable_o,
    output logic [DW-1:0] dp_data_in_o,
    output logic [DW-1:0] dp_t_o,
    input  logic          dp_is_ready_i,
    input  logic          dp_is_end_i,
    input  logic          dp_dop_i,
    input  logic [DW-1:0] dp_gradient_i,
    input  logic [DW-1:0] dp_row_i,
    input  logic [DW-1:0] dp_col_i,
    output logic          res_valid_o,
    input  logic          res_ready_i,
    output logic [DW-1:0] res_row_o,
    output logic [DW-1:0] res_col_o,
    output logic [DW-1:0] res_grad_o,
    output logic          res_edge_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [CW-1:0] edge_count_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
    localparam int EW = 3 * DW + 1;
    state_e        state_q, state_d;
    logic          xfer_dly_q;
    logic [1:0]    occ_q, occ_d;
    logic          wr_ptr_q, rd_ptr_q;
    logic [EW-1:0] fifo_q [2];
    logic [DW-1:0] thresh_q;
    logic [CW-1:0] edge_cnt_q;
    logic          pend, pop, xfer, room, start_ok;

    // datapath outputs reflect a pixel one cycle after it is loaded
    assign pend = xfer_dly_q && dp_is_ready_i;
    assign pop = res_valid_o && res_ready_i;
    assign occ_d = occ_q + 2'(pend) - 2'(pop);
    // counting this cycle's push and pop guarantees the result of a pixel accepted now has a slot
    assign room = occ_d < 2'd2;
    assign xfer = pix_valid_i && pix_ready_o;
    assign start_ok = (state_q == IDLE) && start_i;
    assign dp_enable_o = xfer;
    assign dp_data_in_o = pix_data_i;
    assign dp_t_o = thresh_q;
    assign edge_count_o = edge_cnt_q;
    assign res_valid_o = occ_q != 2'd0;
    assign {res_row_o, res_col_o, res_grad_o, res_edge_o} = fifo_q[rd_ptr_q];

    always_comb begin
        state_d     = state_q;
        pix_ready_o = 1'b0;
        dp_reset_o  = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            IDLE: begin
                dp_reset_o = 1'b1;
                if (start_i) state_d = RUN;
            end
            RUN: begin
                busy_o      = 1'b1;
                pix_ready_o = room;
                if (xfer_dly_q && dp_is_end_i) state_d = DRAIN;
            end
            DRAIN: begin
                busy_o = 1'b1;
                // leave as the last entry pops so Done follows the final pop by one cycle
                if (occ_d == 2'd0 && !pend) state_d = DONE;
            end
            default: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            xfer_dly_q <= 1'b0;
            occ_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            thresh_q   <= '0;
            edge_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            xfer_dly_q <= xfer;
            occ_q      <= occ_d;
            if (pend) begin
                fifo_q[wr_ptr_q] <= {dp_row_i, dp_col_i, dp_gradient_i, dp_dop_i};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            if (start_ok) begin
                thresh_q   <= thresh_in_i;
                edge_cnt_q <= '0;
            end else if (pend && dp_dop_i && edge_cnt_q != '1) begin
                edge_cnt_q <= edge_cnt_q + CW'(1);
            end
        end
    end
endmodule

// File: doc/sobel_frame_controller.md
# sobel_frame_controller

Sequencing controller for the Sobel edge-detection datapath. Accepts a pixel stream from an upstream source through a valid/ready handshake and drives the datapath's enable, data and threshold inputs. Captures each valid window result (row, column, gradient, edge flag) into a 2-entry output FIFO with its own valid/ready handshake. Frames the operation with Start/Busy/Done and keeps a per-frame edge count. Sits between the pixel memory reader and the result writer, directly wrapping one Datapath instance.

## Interface
- DW, 8, pixel, threshold, gradient and row/column width
- CW, 16, EdgeCount width
- Clk  in  1  single clock, all state on rising edge
- Reset  in  1  asynchronous, active-low; clears all state
- Start  in  1  begin frame; honoured only in IDLE
- ThreshIn  in  DW  threshold, latched on accepted Start
- PixValid  in  1  upstream pixel valid
- PixData  in  DW  upstream pixel
- PixReady  out  1  controller accepts pixel this cycle
- Dp_Reset  out  1  datapath clear, active-high
- Dp_Enable  out  1  datapath load strobe
- Dp_DataIn  out  DW  pixel to datapath (= PixData)
- Dp_T  out  DW  latched threshold
- Dp_isReady, Dp_isEnd, Dp_Dop  in  1 each  datapath status
- Dp_Gradient, Dp_Row, Dp_Col  in  DW each  datapath results
- ResValid  out  1  FIFO head valid
- ResReady  in  1  downstream accepts head
- ResRow, ResCol, ResGrad  out  DW each  head fields
- ResEdge  out  1  head edge flag (Dop)
- Busy  out  1  high in RUN and DRAIN
- Done  out  1  one-cycle frame-complete pulse
- EdgeCount  out  CW  edges in current/last frame

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: PixReady=0, Dp_Reset=1. Start=1 -> latch ThreshIn into Dp_T, clear EdgeCount, go RUN.
- RUN: Dp_Reset=0. xfer = PixValid && PixReady; Dp_Enable = xfer (combinational).
- xfer_d = registered xfer. pend = xfer_d && Dp_isReady: datapath outputs reflect the new pixel one cycle after xfer; when pend=1, {Dp_Row, Dp_Col, Dp_Gradient, Dp_Dop} are pushed into the FIFO at that cycle's edge.
- pop = ResValid && ResReady. occ = FIFO occupancy (0..2).
- PixReady = RUN && (occ + pend - pop) < 2. This guarantees no FIFO overflow and allows 1 pixel/cycle when downstream is always ready.
- xfer_d && Dp_isEnd -> go DRAIN (last pixel of frame accepted).
- DRAIN: PixReady=0; capture of the final pending result still occurs. When occ=0 and pend=0 -> DONE.
- DONE: Done=1 for one cycle -> IDLE.
- EdgeCount increments on each push with Dp_Dop=1, saturating at all-ones.
- Start outside IDLE is ignored. Push and pop in the same cycle keep occ unchanged; the FIFO stays in order.
- Results with Dp_isReady=0 (window fill) are discarded and are not counted.

## Timing
- Reset values: state IDLE, PixReady=0, Dp_Enable=0, Dp_Reset=1, Dp_T=0, ResValid=0, ResRow/ResCol/ResGrad=0, ResEdge=0, Busy=0, Done=0, EdgeCount=0, FIFO empty, xfer_d=0.
- Start sampled at cycle 0 -> RUN and PixReady=1 in cycle 1.
- Accepted pixel at cycle t with Dp_isReady=1 at t+1 -> entry pushed at end of t+1 -> ResValid=1 in t+2 (FIFO empty case).
- Last pop at cycle t with nothing pending -> DONE in t+1 (Done=1), IDLE in t+2.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost and no Done is issued.
- Busy falls in the DONE cycle.

## Test plan
- Reset mid-RUN with occ=2: all outputs at reset values asynchronously, Dp_Reset=1. After release, no stale ResValid, and Start begins a clean frame.
- Start with ThreshIn=8'h40, PixValid and ResReady held 1: Dp_T=8'h40, PixReady=1 every RUN cycle, ResValid stays high once filled, one result per accepted pixel after Dp_isReady.
- ResReady=0 throughout RUN: exactly two entries are captured, PixReady drops to 0 and stays 0. No Dp_Enable pulses occur while stalled. Releasing ResReady pops the entries in order with correct Row/Col.
- Datapath model reporting Dop=1 on 5 windows: EdgeCount=5 at Done. A following Start clears it to 0.
- Dp_isEnd on the last pixel with ResReady toggling 1/0: state goes DRAIN, the last result is popped, Done pulses exactly one cycle later, and Busy=0 the cycle after.
- Start pulsed during RUN with ThreshIn=8'hFF: ignored, Dp_T and EdgeCount unchanged.
